axis_deskew: RTL and testbench

- Output-side counterpart of the input skew delay lines in the systolic array.
- The array emits R result lanes staggered in time: the lane r element of a beat arrives r cycles after the lane 0 element.
- axis_deskew delays lane r by (R-1-r) cycles so all lanes realign into one vector, tags it with a valid pipeline, and buffers it in a small FIFO.
- Presents an AXI-Stream master with backpressure; input acceptance is credit-based because the skewed lanes cannot be stalled.

---
 rtl/axis_sa_pkg.sv | 16 +
 rtl/deskew_fifo.sv | 80 ++++++++
 rtl/axis_deskew.sv | 138 +++++++++++++
 tb/tb_axis_deskew.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_sa_pkg.sv
// Shared lane types and width helpers for the systolic-array stream blocks.
package axis_sa_pkg;

    localparam int LANES_DEF = 4;
    localparam int WIDTH_DEF = 8;

    typedef logic [LANES_DEF-1:0][WIDTH_DEF-1:0] lane_vec_t;

    // Pointer and counter widths must stay at least one bit wide for tiny depths.
    function automatic int clog2_safe(input int n);
        int c;
        c = $clog2(n);
        return (c < 1) ? 1 : c;
    endfunction

endpackage

// File: rtl/deskew_fifo.sv
// Circular output buffer for axis_deskew; exposes a credit flag that also counts
// beats still travelling through the deskew pipeline.
module deskew_fifo
    import axis_sa_pkg::*;
#(
    parameter int DW    = 32,
    parameter int DEPTH = 8,
    parameter int INFLW = 1
) (
    input  logic             c,
    input  logic             rng,
    input  logic             rnl,
    input  logic             wr_en_i,
    input  logic [DW-1:0]    wr_data_i,
    input  logic             rd_ready_i,
    output logic             rd_valid_o,
    output logic [DW-1:0]    rd_data_o,
    input  logic [INFLW-1:0] inflight_i,
    output logic             credit_o
);

    localparam int PW = clog2_safe(DEPTH);
    localparam int CW = clog2_safe(DEPTH + 1);

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          empty, full, do_wr, do_rd;

    assign empty      = (count_q == '0);
    assign full       = (count_q == CW'(DEPTH));
    assign do_wr      = wr_en_i && !full;
    assign do_rd      = rd_ready_i && !empty;
    assign rd_valid_o = !empty;
    assign rd_data_o  = empty ? '0 : mem_q[rd_ptr_q];

    // Registered terms only: a pop in this cycle frees its credit one cycle later.
    assign credit_o = (32'(count_q) + 32'(inflight_i)) < DEPTH;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) begin
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        end
        if (do_rd) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        end
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge c or negedge rng) begin
        if (!rng) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (!rnl) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge c) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/axis_deskew.sv
// Realigns the staggered result lanes of the systolic array into one AXI-Stream beat.
// Define AXIS_DESKEW_LAST_EN to carry a per-beat last flag (s_last/m_last).
module axis_deskew
    import axis_sa_pkg::*;
#(
    parameter int R     = LANES_DEF,
    parameter int W     = WIDTH_DEF,
    parameter int DEPTH = 8
) (
    input  logic                c,
    input  logic                rng,
    input  logic                rnl,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [R-1:0][W-1:0] s_data,
`ifdef AXIS_DESKEW_LAST_EN
    input  logic                s_last,
    output logic                m_last,
`endif
    output logic                m_valid,
    input  logic                m_ready,
    output logic [R-1:0][W-1:0] m_data
);

    localparam int INFLW = clog2_safe(R + 1);
`ifdef AXIS_DESKEW_LAST_EN
    localparam int DW = R * W + 1;
`else
    localparam int DW = R * W;
`endif

    logic                handshake;
    logic                tag;
    logic [INFLW-1:0]    inflight;
    logic [R-1:0][W-1:0] aligned;
    logic [DW-1:0]       wr_data;
    logic [DW-1:0]       rd_data;

    assign handshake = s_valid && s_ready;

    // Lane r arrives r cycles late, so it waits R-1-r more cycles to meet lane R-1.
    for (genvar r = 0; r < R; r++) begin : g_lane
        if (r < R - 1) begin : g_dly
            localparam int N = R - 1 - r;
            logic [W-1:0] dly_q [N];

            always_ff @(posedge c or negedge rng) begin
                if (!rng) begin
                    for (int k = 0; k < N; k++) dly_q[k] <= '0;
                end else if (!rnl) begin
                    for (int k = 0; k < N; k++) dly_q[k] <= '0;
                end else begin
                    dly_q[0] <= s_data[r];
                    for (int k = 1; k < N; k++) dly_q[k] <= dly_q[k-1];
                end
            end

            assign aligned[r] = dly_q[N-1];
        end else begin : g_comb
            assign aligned[r] = s_data[r];
        end
    end

    if (R > 1) begin : g_vpipe
        logic [R-2:0] vld_q;

        always_ff @(posedge c or negedge rng) begin
            if (!rng) begin
                vld_q <= '0;
            end else if (!rnl) begin
                vld_q <= '0;
            end else begin
                vld_q[0] <= handshake;
                for (int k = 1; k < R - 1; k++) vld_q[k] <= vld_q[k-1];
            end
        end

        always_comb begin
            inflight = '0;
            for (int k = 0; k < R - 1; k++) begin
                inflight = inflight + INFLW'(vld_q[k]);
            end
        end

        assign tag = vld_q[R-2];
    end else begin : g_vnone
        assign inflight = '0;
        assign tag      = handshake;
    end

`ifdef AXIS_DESKEW_LAST_EN
    logic tag_last;

    if (R > 1) begin : g_lpipe
        logic [R-2:0] last_q;

        always_ff @(posedge c or negedge rng) begin
            if (!rng) begin
                last_q <= '0;
            end else if (!rnl) begin
                last_q <= '0;
            end else begin
                last_q[0] <= s_last && handshake;
                for (int k = 1; k < R - 1; k++) last_q[k] <= last_q[k-1];
            end
        end

        assign tag_last = last_q[R-2];
    end else begin : g_lnone
        assign tag_last = s_last && handshake;
    end

    assign wr_data = {tag_last, aligned};
    assign m_last  = rd_data[DW-1];
    assign m_data  = rd_data[R*W-1:0];
`else
    assign wr_data = aligned;
    assign m_data  = rd_data;
`endif

    deskew_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .INFLW (INFLW)
    ) u_fifo (
        .c          (c),
        .rng        (rng),
        .rnl        (rnl),
        .wr_en_i    (tag),
        .wr_data_i  (wr_data),
        .rd_ready_i (m_ready),
        .rd_valid_o (m_valid),
        .rd_data_o  (rd_data),
        .inflight_i (inflight),
        .credit_o   (s_ready)
    );

endmodule

// File: tb/tb_axis_deskew.sv
// Self-checking bench for axis_deskew: a DEPTH=8 instance for the main tests and a
// DEPTH=5 instance for pointer wrap; honours AXIS_DESKEW_LAST_EN when defined.
module tb_axis_deskew;
    import axis_sa_pkg::*;

    localparam int RL      = LANES_DEF;
    localparam int WL      = WIDTH_DEF;
    localparam int DEPTH_A = 8;
    localparam int DEPTH_B = 5;

    typedef struct {
        bit        sValid;
        lane_vec_t sData;
        bit        mReady;
        bit        expValid;
        lane_vec_t expData;
        bit        expReady;
    } vecRec_t;

    logic      clk = 1'b0;
    logic      rstGlobal;
    logic      rstLocal;
    logic [1:0] sValid, sReady, mValid, mReady;
    lane_vec_t sDataA, sDataB, mDataA, mDataB;
`ifdef AXIS_DESKEW_LAST_EN
    logic [1:0] sLast, mLast;
    bit        curLast [2];
    bit        prevLast [2];
    bit        lastQA [$];
    bit        lastQB [$];
`endif

    int        checks = 0;
    int        errors = 0;
    int        accCnt [2];
    int        outCnt [2];
    bit        popped [2];
    bit        obsReady [2];
    bit        prevValid [2];
    bit        prevReady [2];
    lane_vec_t prevData [2];
    bit        histV [2][RL];
    lane_vec_t histD [2][RL];
    lane_vec_t qA [$];
    lane_vec_t qB [$];
    vecRec_t   tbl [7];

    always #5 clk = ~clk;

    axis_deskew #(.R(RL), .W(WL), .DEPTH(DEPTH_A)) dutA (
        .c       (clk),
        .rng     (rstGlobal),
        .rnl     (rstLocal),
        .s_valid (sValid[0]),
        .s_ready (sReady[0]),
        .s_data  (sDataA),
`ifdef AXIS_DESKEW_LAST_EN
        .s_last  (sLast[0]),
        .m_last  (mLast[0]),
`endif
        .m_valid (mValid[0]),
        .m_ready (mReady[0]),
        .m_data  (mDataA)
    );

    axis_deskew #(.R(RL), .W(WL), .DEPTH(DEPTH_B)) dutB (
        .c       (clk),
        .rng     (rstGlobal),
        .rnl     (rstLocal),
        .s_valid (sValid[1]),
        .s_ready (sReady[1]),
        .s_data  (sDataB),
`ifdef AXIS_DESKEW_LAST_EN
        .s_last  (sLast[1]),
        .m_last  (mLast[1]),
`endif
        .m_valid (mValid[1]),
        .m_ready (mReady[1]),
        .m_data  (mDataB)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic clearModel();
        for (int d = 0; d < 2; d++) begin
            prevValid[d] = 1'b0;
            prevReady[d] = 1'b1;
            for (int j = 0; j < RL; j++) histV[d][j] = 1'b0;
        end
        qA.delete();
        qB.delete();
`ifdef AXIS_DESKEW_LAST_EN
        lastQA.delete();
        lastQB.delete();
`endif
    endtask

    // One clock cycle: drive skewed lanes from the history, then score handshakes and pops.
    task automatic applyStimulus(input bit wantA, input bit rdyA, input bit wantB, input bit rdyB);
        bit        want [2];
        bit        rdy [2];
        lane_vec_t beat [2];
        lane_vec_t shown;
        lane_vec_t got;
        lane_vec_t expV;
        bit        hs;
        want[0] = wantA;
        want[1] = wantB;
        rdy[0]  = rdyA;
        rdy[1]  = rdyB;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            beat[d]  = lane_vec_t'($urandom);
            shown    = lane_vec_t'($urandom);
            shown[0] = beat[d][0];
            for (int r = 1; r < RL; r++) begin
                if (histV[d][r]) shown[r] = histD[d][r][r];
            end
            sValid[d] = want[d];
            mReady[d] = rdy[d];
            if (d == 0) sDataA = shown;
            else        sDataB = shown;
`ifdef AXIS_DESKEW_LAST_EN
            sLast[d] = want[d] && curLast[d];
`endif
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            got = (d == 0) ? mDataA : mDataB;
            if (prevValid[d] && !prevReady[d]) begin
                checkOutput($sformatf("hold_valid_%0d", d), 64'(mValid[d]), 64'd1);
                checkOutput($sformatf("hold_data_%0d", d), 64'(got), 64'(prevData[d]));
`ifdef AXIS_DESKEW_LAST_EN
                checkOutput($sformatf("hold_last_%0d", d), 64'(mLast[d]), 64'(prevLast[d]));
`endif
            end
            obsReady[d] = sReady[d];
            hs          = want[d] && sReady[d];
            popped[d]   = mValid[d] && rdy[d];
            if (hs) begin
                accCnt[d]++;
                if (d == 0) qA.push_back(beat[d]);
                else        qB.push_back(beat[d]);
`ifdef AXIS_DESKEW_LAST_EN
                if (d == 0) lastQA.push_back(curLast[d]);
                else        lastQB.push_back(curLast[d]);
`endif
            end
            if (popped[d]) begin
                outCnt[d]++;
                if ((d == 0 && qA.size() == 0) || (d == 1 && qB.size() == 0)) begin
                    checkOutput($sformatf("unexpected_out_%0d", d), 64'd1, 64'd0);
                end else begin
                    expV = (d == 0) ? qA.pop_front() : qB.pop_front();
                    checkOutput($sformatf("sb_data_%0d_beat%0d", d, outCnt[d]), 64'(got), 64'(expV));
`ifdef AXIS_DESKEW_LAST_EN
                    checkOutput($sformatf("sb_last_%0d_beat%0d", d, outCnt[d]), 64'(mLast[d]),
                                64'((d == 0) ? lastQA.pop_front() : lastQB.pop_front()));
`endif
                end
            end
            prevValid[d] = mValid[d];
            prevReady[d] = rdy[d];
            prevData[d]  = got;
`ifdef AXIS_DESKEW_LAST_EN
            prevLast[d]  = mLast[d];
`endif
            for (int j = RL - 1; j >= 2; j--) begin
                histV[d][j] = histV[d][j-1];
                histD[d][j] = histD[d][j-1];
            end
            histV[d][1] = hs;
            histD[d][1] = beat[d];
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_m_valid"}, 64'(mValid[0]), 64'd0);
        checkOutput({tag, "_m_data"}, 64'(mDataA), 64'd0);
        checkOutput({tag, "_s_ready"}, 64'(sReady[0]), 64'd1);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        int first;
        int last;
        int drops;

        tbl[0] = '{1'b1, 32'hEEDDCC10, 1'b1, 1'b0, 32'h0, 1'b1};
        tbl[1] = '{1'b0, 32'hEEDD21AA, 1'b1, 1'b0, 32'h0, 1'b1};
        tbl[2] = '{1'b0, 32'hEE32BBAA, 1'b1, 1'b0, 32'h0, 1'b1};
        tbl[3] = '{1'b0, 32'h43CCBBAA, 1'b1, 1'b0, 32'h0, 1'b1};
        tbl[4] = '{1'b0, 32'h55667788, 1'b1, 1'b1, 32'h43322110, 1'b1};
        tbl[5] = '{1'b0, 32'h99AABBCC, 1'b1, 1'b0, 32'h0, 1'b1};
        tbl[6] = '{1'b0, 32'h00000000, 1'b1, 1'b0, 32'h0, 1'b1};

        sValid    = '0;
        mReady    = 2'b11;
        sDataA    = '0;
        sDataB    = '0;
        rstGlobal = 1'b0;
        rstLocal  = 1'b1;
`ifdef AXIS_DESKEW_LAST_EN
        sLast      = '0;
        curLast[0] = 1'b0;
        curLast[1] = 1'b0;
`endif
        for (int d = 0; d < 2; d++) begin
            accCnt[d] = 0;
            outCnt[d] = 0;
        end
        clearModel();

        #12;
        checkResetState("reset");
        checkOutput("reset_b_m_valid", 64'(mValid[1]), 64'd0);
        checkOutput("reset_b_s_ready", 64'(sReady[1]), 64'd1);
        @(negedge clk);
        rstGlobal = 1'b1;

        $display("[TB] single beat table");
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            sValid[0] = tbl[i].sValid;
            sDataA    = tbl[i].sData;
            mReady[0] = tbl[i].mReady;
            #1;
            checkOutput($sformatf("tbl%0d_m_valid", i), 64'(mValid[0]), 64'(tbl[i].expValid));
            checkOutput($sformatf("tbl%0d_s_ready", i), 64'(sReady[0]), 64'(tbl[i].expReady));
            if (tbl[i].expValid) begin
                checkOutput($sformatf("tbl%0d_m_data", i), 64'(mDataA), 64'(tbl[i].expData));
            end
        end

        $display("[TB] streaming 20 beats");
        base  = outCnt[0];
        first = -1;
        last  = -1;
        drops = 0;
        for (int i = 0; i < 32; i++) begin
            applyStimulus(i < 20, 1'b1, 1'b0, 1'b1);
            if (i < 20 && !obsReady[0]) drops++;
            if (popped[0]) begin
                if (first < 0) first = i;
                last = i;
            end
        end
        checkOutput("stream_ready_drops", 64'(drops), 64'd0);
        checkOutput("stream_out_count", 64'(outCnt[0] - base), 64'd20);
        checkOutput("stream_first_latency", 64'(first), 64'(RL));
        checkOutput("stream_contiguous", 64'(last - first), 64'd19);

        $display("[TB] backpressure");
        base = accCnt[0];
        for (int i = 0; i < 14; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("bp_accepted", 64'(accCnt[0] - base), 64'(DEPTH_A));
        base = outCnt[0];
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("bp_ready_on_first_pop", 64'(obsReady[0]), 64'd0);
        checkOutput("bp_first_pop", 64'(popped[0]), 64'd1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("bp_ready_after_pop", 64'(obsReady[0]), 64'd1);
        for (int i = 0; i < 30 && (outCnt[0] - base) < DEPTH_A; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("bp_drained", 64'(outCnt[0] - base), 64'(DEPTH_A));

        $display("[TB] wrap on DEPTH=5 with random m_ready");
        base = accCnt[1];
        first = outCnt[1];
        for (int i = 0; i < 400 && (outCnt[1] - first) < 17; i++) begin
            applyStimulus(1'b0, 1'b1, (accCnt[1] - base) < 17, 1'($urandom_range(0, 1)));
        end
        checkOutput("wrap_accepted", 64'(accCnt[1] - base), 64'd17);
        checkOutput("wrap_out_count", 64'(outCnt[1] - first), 64'd17);
        checkOutput("wrap_sb_empty", 64'(qB.size()), 64'd0);

        $display("[TB] synchronous clear mid-flight");
        base = accCnt[0];
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("srst_accepted", 64'(accCnt[0] - base), 64'd5);
        @(negedge clk);
        sValid   = '0;
        rstLocal = 1'b0;
        @(negedge clk);
        rstLocal = 1'b1;
        #1;
        checkResetState("srst");
        clearModel();
        base = outCnt[0];
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("srst_no_stale", 64'(outCnt[0] - base), 64'd0);

        $display("[TB] asynchronous reset mid-flight");
        base = accCnt[0];
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("arst_accepted", 64'(accCnt[0] - base), 64'd5);
        @(negedge clk);
        sValid = '0;
        #2;
        rstGlobal = 1'b0;
        #1;
        checkResetState("arst");
        #1;
        rstGlobal = 1'b1;
        clearModel();
        base = outCnt[0];
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("arst_no_stale", 64'(outCnt[0] - base), 64'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("arst_recover", 64'(outCnt[0] - base), 64'd1);

`ifdef AXIS_DESKEW_LAST_EN
        $display("[TB] last flag");
        base = outCnt[0];
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        curLast[0] = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        curLast[0] = 1'b0;
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("last_head_beat0", 64'(mLast[0]), 64'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
            checkOutput($sformatf("last_held_%0d", i), 64'(mLast[0]), 64'd1);
        end
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("last_out_count", 64'(outCnt[0] - base), 64'd3);
`endif

        checkOutput("sb_empty_a", 64'(qA.size()), 64'd0);
        checkOutput("sb_empty_b", 64'(qB.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
